// File: rtl/sayuru_port_arbiter.sv
// Two-port request arbiter in front of a single cache port.
// One transaction is outstanding at a time. The winner is chosen in IDLE and
// its payload is latched. The request is then held toward the cache until it
// is granted, and the single response is routed back to the winning port.
module sayuru_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // requester side
  input  logic [1:0]                  in_req_i,
  output logic [1:0]                  in_gnt_o,
  output logic [1:0]                  in_rvalid_o,
  input  logic [2*ADDR_WIDTH-1:0]     in_addr_i,
  input  logic [1:0]                  in_we_i,
  input  logic [2*(DATA_WIDTH/8)-1:0] in_be_i,
  input  logic [2*DATA_WIDTH-1:0]     in_wdata_i,
  output logic [DATA_WIDTH-1:0]       in_rdata_o,
  // cache side
  output logic                        out_req_o,
  input  logic                        out_gnt_i,
  input  logic                        out_rvalid_i,
  output logic [ADDR_WIDTH-1:0]       out_addr_o,
  output logic                        out_we_o,
  output logic [(DATA_WIDTH/8)-1:0]   out_be_o,
  output logic [DATA_WIDTH-1:0]       out_wdata_o,
  input  logic [DATA_WIDTH-1:0]       out_rdata_i,
  // status
  output logic                        busy_o,
  output logic [31:0]                 conflict_count
);

  localparam int unsigned BW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  state_e                  state_q, state_d;
  logic                    prio_q, prio_d;
  logic                    win_q, win_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [BW-1:0]           be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [31:0]             conflict_q, conflict_d;
  logic                    out_req_q, out_req_d;
  logic                    busy_q, busy_d;

  logic                    contended;
  logic                    pick;
  logic                    grant_fire;
  logic                    resp_fire;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    sel_we;
  logic [BW-1:0]           sel_be;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // Arbitration: a lone request wins outright, a contended one follows the pointer.
  // The grant is gated by rst_n because the state already reads IDLE during reset.
  always_comb begin
    contended  = (in_req_i == 2'b11);
    pick       = contended ? prio_q : in_req_i[1];
    grant_fire = rst_n && (state_q == IDLE) && (in_req_i != 2'b00);
    in_gnt_o   = 2'b00;
    if (grant_fire) begin
      in_gnt_o = pick ? 2'b10 : 2'b01;
    end
  end

  // Payload selection for the winning requester.
  always_comb begin
    sel_addr  = pick ? in_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : in_addr_i[ADDR_WIDTH-1:0];
    sel_we    = pick ? in_we_i[1] : in_we_i[0];
    sel_be    = pick ? in_be_i[2*BW-1:BW] : in_be_i[BW-1:0];
    sel_wdata = pick ? in_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : in_wdata_i[DATA_WIDTH-1:0];
  end

  // Next-state, payload latch, priority pointer and conflict counter.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    win_d      = win_q;
    addr_d     = addr_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    conflict_d = conflict_q;

    case (state_q)
      IDLE: begin
        if (in_req_i != 2'b00) begin
          state_d = ISSUE;
          win_d   = pick;
          addr_d  = sel_addr;
          we_d    = sel_we;
          be_d    = sel_be;
          wdata_d = sel_wdata;
          if (contended) begin
            prio_d = ~pick;
          end
        end
        if (contended && (conflict_q != '1)) begin
          conflict_d = conflict_q + 32'd1;
        end
      end
      ISSUE: begin
        if (out_gnt_i) begin
          state_d = out_rvalid_i ? IDLE : RESP;
        end
      end
      RESP: begin
        if (out_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    out_req_d = (state_d == ISSUE);
    busy_d    = (state_d != IDLE);
  end

  // Response routing: a response is accepted in RESP, or in ISSUE when it arrives with the grant.
  always_comb begin
    resp_fire   = out_rvalid_i &&
                  ((state_q == RESP) || ((state_q == ISSUE) && out_gnt_i));
    in_rvalid_o = 2'b00;
    if (resp_fire) begin
      in_rvalid_o = win_q ? 2'b10 : 2'b01;
    end
  end

  // All arbiter state, including the registered request/busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      win_q      <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      conflict_q <= '0;
      out_req_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      win_q      <= win_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      conflict_q <= conflict_d;
      out_req_q  <= out_req_d;
      busy_q     <= busy_d;
    end
  end

  assign out_req_o      = out_req_q;
  assign busy_o         = busy_q;
  assign out_addr_o     = addr_q;
  assign out_we_o       = we_q;
  assign out_be_o       = be_q;
  assign out_wdata_o    = wdata_q;
  assign in_rdata_o     = out_rdata_i;
  assign conflict_count = conflict_q;

endmodule

// File: tb/tb_sayuru_port_arbiter.sv
// Scoreboard bench for sayuru_port_arbiter. The stimulus process predicts each
// grant from a round-robin model and queues the expected transaction. A random
// cache model queues each expected response. Monitors pop the queues and
// compare whenever the arbiter presents a grant, a request or a response.
module tb_sayuru_port_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned NR = 150;

  typedef struct {
    logic          idx;
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    logic          idx;
    logic [DW-1:0] rdata;
  } rsp_t;

  logic            clk;
  logic            rst_n;
  logic [1:0]      in_req_i;
  logic [1:0]      in_gnt_o;
  logic [1:0]      in_rvalid_o;
  logic [2*AW-1:0] in_addr_i;
  logic [1:0]      in_we_i;
  logic [2*BW-1:0] in_be_i;
  logic [2*DW-1:0] in_wdata_i;
  logic [DW-1:0]   in_rdata_o;
  logic            out_req_o;
  logic            out_gnt_i;
  logic            out_rvalid_i;
  logic [AW-1:0]   out_addr_o;
  logic            out_we_o;
  logic [BW-1:0]   out_be_o;
  logic [DW-1:0]   out_wdata_o;
  logic [DW-1:0]   out_rdata_i;
  logic            busy_o;
  logic [31:0]     conflict_count;

  sayuru_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_req_i       (in_req_i),
    .in_gnt_o       (in_gnt_o),
    .in_rvalid_o    (in_rvalid_o),
    .in_addr_i      (in_addr_i),
    .in_we_i        (in_we_i),
    .in_be_i        (in_be_i),
    .in_wdata_i     (in_wdata_i),
    .in_rdata_o     (in_rdata_o),
    .out_req_o      (out_req_o),
    .out_gnt_i      (out_gnt_i),
    .out_rvalid_i   (out_rvalid_i),
    .out_addr_o     (out_addr_o),
    .out_we_o       (out_we_o),
    .out_be_o       (out_be_o),
    .out_wdata_o    (out_wdata_o),
    .out_rdata_i    (out_rdata_i),
    .busy_o         (busy_o),
    .conflict_count (conflict_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_prio;
  int m_conflicts;

  // scoreboard queues
  txn_t exp_gnt_q[$];
  logic exp_win_q[$];
  rsp_t exp_rsp_q[$];

  // requester payload slots
  logic [AW-1:0] addr_s [2];
  logic          we_s   [2];
  logic [BW-1:0] be_s   [2];
  logic [DW-1:0] wd_s   [2];

  // handshakes between stimulus and cache model
  logic cache_active = 1'b0;
  logic rst_test     = 1'b0;
  logic rst_done     = 1'b0;
  logic in_resp_flag = 1'b0;
  logic late_done    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [1:0] port_bit(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  task automatic drive_payloads();
    in_addr_i  = {addr_s[1], addr_s[0]};
    in_we_i    = {we_s[1], we_s[0]};
    in_be_i    = {be_s[1], be_s[0]};
    in_wdata_i = {wd_s[1], wd_s[0]};
  endtask

  task automatic new_payloads();
    for (int k = 0; k < 2; k++) begin
      addr_s[k] = AW'($urandom);
      we_s[k]   = 1'($urandom);
      be_s[k]   = BW'($urandom);
      wd_s[k]   = DW'($urandom);
    end
    drive_payloads();
  endtask

  // Round-robin model: a lone requester wins; under contention the pointer wins
  // and the loser becomes the pointer.
  task automatic expect_txn(input logic [1:0] r, output int w);
    txn_t t;
    if (r == 2'b11) begin
      w = m_prio;
      m_prio = 1 - m_prio;
      m_conflicts++;
    end else begin
      w = r[1] ? 1 : 0;
    end
    t.idx   = w[0];
    t.addr  = addr_s[w];
    t.we    = we_s[w];
    t.be    = be_s[w];
    t.wdata = wd_s[w];
    exp_gnt_q.push_back(t);
    exp_win_q.push_back(t.idx);
  endtask

  task automatic wait_grant(input string name);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (in_gnt_o != 2'b00) got = 1'b1;
    end
    if (!got) fail_now(name, 64'(in_gnt_o), 64'd1);
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (exp_gnt_q.size() == 0 && exp_win_q.size() == 0 && exp_rsp_q.size() == 0 &&
          !busy_o && !cache_active) ok = 1'b1;
    end
    if (!ok) fail_now(name, 64'(exp_rsp_q.size()), 64'd0);
  endtask

  // Stimulus
  initial begin : stim
    int  w;
    int  last_w;
    bit  pending;
    bit  got;

    m_prio      = 0;
    m_conflicts = 0;
    rst_n       = 1'b0;
    in_req_i    = 2'b11;
    new_payloads();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 64'(in_gnt_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_out_req", 64'(out_req_o), 64'd0);
    check("rst_rvalid", 64'(in_rvalid_o), 64'd0);
    @(posedge clk); #1;
    in_req_i = 2'b00;
    rst_n    = 1'b1;
    @(negedge clk);
    check("rst_conflicts", 64'(conflict_count), 64'd0);
    check("rst_addr", 64'(out_addr_o), 64'd0);
    check("rst_we", 64'(out_we_o), 64'd0);
    check("rst_be", 64'(out_be_o), 64'd0);
    check("rst_wdata", 64'(out_wdata_o), 64'd0);
    @(posedge clk); #1;

    // Random rounds; a losing requester may keep requesting through the busy period.
    pending = 1'b0;
    last_w  = 0;
    for (int r = 0; r < int'(NR); r++) begin
      if (!pending) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
        new_payloads();
        in_req_i = 2'($urandom_range(1, 3));
        expect_txn(in_req_i, last_w);
      end
      wait_grant("grant_wait");
      @(posedge clk); #1;
      if (in_req_i == 2'b11 && r < int'(NR) - 1 && $urandom_range(0, 1) == 1) begin
        in_req_i = (last_w == 0) ? 2'b10 : 2'b01;
        expect_txn(in_req_i, last_w);
        pending = 1'b1;
      end else begin
        in_req_i = 2'b00;
        pending  = 1'b0;
      end
    end
    drain("drain_random");
    check("conflicts_random", 64'(conflict_count), 64'(m_conflicts));
    @(posedge clk); #1;

    // Reset while a read is waiting in RESP, then a late response.
    rst_test  = 1'b1;
    addr_s[0] = 16'h0040;
    we_s[0]   = 1'b0;
    drive_payloads();
    in_req_i = 2'b01;
    expect_txn(2'b01, w);
    wait_grant("rst_test_grant");
    @(posedge clk); #1;
    in_req_i = 2'b00;
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      if (in_resp_flag) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!got) fail_now("resp_wait", 64'(busy_o), 64'd1);
    rst_n    = 1'b0;
    in_req_i = 2'b11;
    @(negedge clk);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_out_req", 64'(out_req_o), 64'd0);
    check("mid_rst_gnt", 64'(in_gnt_o), 64'd0);
    check("mid_rst_rvalid", 64'(in_rvalid_o), 64'd0);
    check("mid_rst_conflicts", 64'(conflict_count), 64'd0);
    check("mid_rst_addr", 64'(out_addr_o), 64'd0);
    @(posedge clk); #1;
    in_req_i    = 2'b00;
    rst_n       = 1'b1;
    m_prio      = 0;
    m_conflicts = 0;
    rst_done    = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (out_rvalid_i) got = 1'b1;
    end
    if (!got) fail_now("late_rvalid_wait", 64'(out_rvalid_i), 64'd1);
    check("late_rvalid_dropped", 64'(in_rvalid_o), 64'd0);
    check("late_rvalid_busy", 64'(busy_o), 64'd0);
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      if (late_done) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) fail_now("late_done_wait", 64'(late_done), 64'd1);
    @(posedge clk); #1;
    rst_test = 1'b0;

    // First contention after reset goes to port 0.
    new_payloads();
    in_req_i = 2'b11;
    expect_txn(2'b11, w);
    wait_grant("post_rst_grant");
    @(posedge clk); #1;
    in_req_i = 2'b00;
    drain("drain_final");
    check("conflicts_final", 64'(conflict_count), 64'(m_conflicts));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Cache model: random grant and response delays, stray rvalid pulses that must be ignored.
  initial begin : cache_model
    int   gdly;
    int   rdly;
    logic widx;
    out_gnt_i    = 1'b0;
    out_rvalid_i = 1'b0;
    out_rdata_i  = '0;
    forever begin
      @(posedge clk); #1;
      out_gnt_i   = 1'b0;
      out_rdata_i = DW'($urandom);
      if (rst_n && out_req_o) begin
        cache_active = 1'b1;
        if (exp_win_q.size() == 0) begin
          fail_now("req_without_expectation", 64'(out_req_o), 64'd0);
          widx = 1'b0;
        end else begin
          widx = exp_win_q.pop_front();
        end
        if (rst_test) begin
          out_gnt_i    = 1'b1;
          out_rvalid_i = 1'b0;
          @(posedge clk); #1;
          out_gnt_i    = 1'b0;
          in_resp_flag = 1'b1;
          for (int c = 0; c < 64 && !rst_done; c++) begin
            @(posedge clk); #1;
          end
          out_rvalid_i = 1'b1;
          out_rdata_i  = DW'($urandom);
          @(posedge clk); #1;
          out_rvalid_i = 1'b0;
          cache_active = 1'b0;
          late_done    = 1'b1;
        end else begin
          gdly = $urandom_range(0, 2);
          for (int i = 0; i < gdly; i++) begin
            out_gnt_i    = 1'b0;
            out_rvalid_i = ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
          end
          out_gnt_i = 1'b1;
          rdly = $urandom_range(0, 2);
          if (rdly == 0) begin
            out_rvalid_i = 1'b1;
            out_rdata_i  = DW'($urandom);
            exp_rsp_q.push_back('{idx: widx, rdata: out_rdata_i});
            @(posedge clk); #1;
          end else begin
            out_rvalid_i = 1'b0;
            @(posedge clk); #1;
            out_gnt_i = 1'b0;
            for (int i = 1; i < rdly; i++) begin
              out_rdata_i = DW'($urandom);
              @(posedge clk); #1;
            end
            out_rvalid_i = 1'b1;
            out_rdata_i  = DW'($urandom);
            exp_rsp_q.push_back('{idx: widx, rdata: out_rdata_i});
            @(posedge clk); #1;
          end
          out_gnt_i    = 1'b0;
          out_rvalid_i = 1'b0;
          cache_active = 1'b0;
        end
      end else begin
        out_rvalid_i = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Grant and request monitor.
  initial begin : req_mon
    txn_t cur;
    bit   pend;
    bit   prev_req;
    pend     = 1'b0;
    prev_req = 1'b0;
    cur      = '{idx: 1'b0, addr: '0, we: 1'b0, be: '0, wdata: '0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend     = 1'b0;
        prev_req = 1'b0;
      end else begin
        if (pend) begin
          check("req_latency", 64'(out_req_o), 64'd1);
          pend = 1'b0;
        end else if (out_req_o && !prev_req) begin
          fail_now("spurious_req", 64'(out_req_o), 64'd0);
        end
        if (out_req_o) begin
          check("out_addr", 64'(out_addr_o), 64'(cur.addr));
          check("out_we", 64'(out_we_o), 64'(cur.we));
          check("out_be", 64'(out_be_o), 64'(cur.be));
          check("out_wdata", 64'(out_wdata_o), 64'(cur.wdata));
        end
        if (in_gnt_o != 2'b00) begin
          if (cache_active) fail_now("gnt_while_busy", 64'(in_gnt_o), 64'd0);
          if (exp_gnt_q.size() == 0) begin
            fail_now("gnt_unexpected", 64'(in_gnt_o), 64'd0);
          end else begin
            cur = exp_gnt_q.pop_front();
            check("gnt_port", 64'(in_gnt_o), 64'(port_bit(cur.idx)));
            pend = 1'b1;
          end
        end
        prev_req = out_req_o;
      end
    end
  end

  // Response and status monitor.
  initial begin : rsp_mon
    rsp_t e;
    forever begin
      @(negedge clk);
      check("rdata_pass", 64'(in_rdata_o), 64'(out_rdata_i));
      if (rst_n && in_rvalid_o != 2'b00) begin
        if (exp_rsp_q.size() == 0) begin
          fail_now("rvalid_unexpected", 64'(in_rvalid_o), 64'd0);
        end else begin
          e = exp_rsp_q.pop_front();
          check("rvalid_port", 64'(in_rvalid_o), 64'(port_bit(e.idx)));
          check("rvalid_rdata", 64'(in_rdata_o), 64'(e.rdata));
        end
      end
      if (rst_n && !rst_test) check("busy", 64'(busy_o), 64'(cache_active));
    end
  end

  initial begin : watchdog
    #500000;
    fail_now("watchdog", 64'(busy_o), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "time limit reached");
  end

endmodule
